multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset core.
- Sits directly upstream of the datapath: consumes the 6-bit opCode from the instruction register and produces every datapath control strobe.
- Inserts wait states to cover the synchronous-read latency of the 64K×32 unified memory.
- Reports halt, illegal-opcode and retired-instruction status.

Parameters:
- MEM_LAT, 1, extra wait cycles after a memory read is issued before its data is valid (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opCode  in  6  IR[31:26] from the datapath.
- PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath strobes.
- PCSource  out  2  00 = ALU, 01 = ALU (branch target), 10 = jump target.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode funct.
- ALUSrcB  out  3  000 = B, 001 = const 4, 010 = sign-ext, 011 = sign-ext<<2; bit 2 always 0.
- halted  out  1  core stopped.
- illegal_op  out  1  sticky; an unsupported opcode was decoded.
- instr_count  out  CNT_W  instructions fetched since reset.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (reset=0, async): state=FETCH, wait counter=0, instr_count=0, halted=0, illegal_op=0. All strobes are gated to 0 while reset is low, mid-instruction included. The first FETCH cycle follows the first clk edge after release.
- Strobes are Moore outputs: decoded from state plus the wait counter only. Any strobe not listed below is 0.
- FETCH:
  - Every cycle: MemRead=1, IorD=0.
  - Lasts MEM_LAT+1 cycles.
  - Last cycle only: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=001, ALUOp=00, PCSource=00, instr_count+=1 (wraps).
  - Then → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=011, ALUOp=00. Next state by opCode:
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000000 (R-type) → EXEC_R
  - 001000 (addi) → EXEC_I
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 111111 (halt) → HALT
  - anything else → HALT and illegal_op ← 1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=010, ALUOp=00. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1, address held for MEM_LAT+1 cycles → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, one cycle → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=000, ALUOp=10 → R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, ALU inputs held as in EXEC_R → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=010, ALUOp=00 → I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, ALU inputs held as in EXEC_I → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=000, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- HALT: all strobes 0, halted=1, absorbing until reset.
- Cycle counts at MEM_LAT=1: lw 7, sw 5, R-type 5, addi 5, beq 4, j 4. Each wait-stretched state adds (MEM_LAT−1) cycles at larger MEM_LAT.
- The wait counter clears on entry to every state. It is CLOG2(MEM_LAT+1) bits wide and never wraps.
- opCode is sampled only in DECODE. Changes in other states are ignored.
- MemRead and MemWrite are never asserted together. IRWrite is never asserted outside FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT)
  - the 4-bit state enum
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, mem_wait_counter: a load/clear/done counter parameterised by MEM_LAT that drives the last-cycle flag.

Test Plan:
- Reset, then drive opCode=000000 → state sequence FETCH, FETCH, DECODE, EXEC_R, R_WB, FETCH. IRWrite=1 only in cycle 2; RegWrite=1 and RegDst=1 in cycle 5; instr_count=1.
- opCode=100011 (lw), MEM_LAT=3 → FETCH held 4 cycles; MEM_READ held 4 cycles with IorD=1; MEM_WB asserts MemtoReg=1 and RegWrite=1; total 11 cycles.
- opCode=101011 (sw) → MemWrite=1 for exactly one cycle with IorD=1; RegWrite never 1; next state FETCH.
- opCode=000100 (beq) then 000010 (j) → BRANCH cycle shows PCWriteCond=1, ALUOp=01, PCSource=01. JUMP cycle shows PCWrite=1, PCSource=10.
- opCode=010101 → DECODE → HALT. halted=1 and illegal_op=1 persist for 20 cycles with all strobes 0 and instr_count frozen. opCode=111111 gives halted=1 with illegal_op=0.
- Reset driven low asynchronously in the middle of MEM_READ → strobes 0 with no clock edge. After release the FSM restarts in FETCH with instr_count=0 and illegal_op=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle core controller: opcodes, FSM states,
// datapath select codes and the state-to-strobe decode.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_EXEC_I    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd12
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [2:0] SRCB_B      = 3'b000;
   localparam logic [2:0] SRCB_FOUR   = 3'b001;
   localparam logic [2:0] SRCB_IMM    = 3'b010;
   localparam logic [2:0] SRCB_IMM_SH = 3'b011;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write_cond;
      logic       pc_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [2:0] alu_src_b;
   } ctrl_t;

   // last = final cycle of a wait-stretched state
   function automatic ctrl_t mc_decode(input state_t st, input logic last);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read = 1'b1;
            if (last) begin
               c.ir_write  = 1'b1;
               c.pc_write  = 1'b1;
               c.alu_src_b = SRCB_FOUR;
               c.alu_op    = ALU_ADD;
               c.pc_source = PCSRC_ALU;
            end
         end
         S_DECODE: c.alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC_R, S_R_WB: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_FUNCT;
            c.reg_write = (st == S_R_WB);
            c.reg_dst   = (st == S_R_WB);
         end
         S_EXEC_I, S_I_WB: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.reg_write = (st == S_I_WB);
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_BRANCH;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: clears on state entry, counts up to MEM_LAT and holds;
// done flags the last cycle, done_nxt is the same flag one edge early.
module mem_wait_counter #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic done,
   output logic done_nxt
);

   localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] TC = CW'(MEM_LAT);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (count_en && (cnt != TC))
         cnt_nxt = cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   assign done     = (cnt == TC);
   assign done_nxt = (cnt_nxt == TC);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset core; strobes are registered
// from the next state so they are glitch-free and forced low by reset.
//
// state       | meaning
// FETCH       | read instruction, MEM_LAT+1 cycles, last one loads IR / PC+4
// DECODE      | register read, branch target precompute, opCode dispatch
// MEM_ADDR    | base + offset for lw/sw
// MEM_READ    | data read, MEM_LAT+1 cycles
// MEM_WB      | load result to rt
// MEM_WRITE   | store word
// EXEC_R      | R-type ALU op
// R_WB        | ALU result to rd
// EXEC_I      | addi ALU op
// I_WB        | ALU result to rt
// BRANCH      | beq compare and conditional PC update
// JUMP        | PC <- jump target
// HALT        | stopped until reset
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opCode,
   output logic             PCWriteCond,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             RegDst,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic [2:0]       ALUSrcB,
   output logic             halted,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_dbg
);

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl_q;
   logic   run;
   logic   mem_is_lw;
   logic   op_bad;
   logic   wait_clear;
   logic   wait_en;
   logic   wait_done;
   logic   wait_done_nxt;

   mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .clear    (wait_clear),
      .count_en (wait_en),
      .done     (wait_done),
      .done_nxt (wait_done_nxt)
   );

   always_comb begin
      state_nxt = state;
      op_bad    = 1'b0;
      case (state)
         S_FETCH:    if (wait_done) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opCode)
               OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
               OP_RTYPE:     state_nxt = S_EXEC_R;
               OP_ADDI:      state_nxt = S_EXEC_I;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               OP_HALT:      state_nxt = S_HALT;
               default: begin
                  state_nxt = S_HALT;
                  op_bad    = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_nxt = mem_is_lw ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: if (wait_done) state_nxt = S_MEM_WB;
         S_EXEC_R:   state_nxt = S_R_WB;
         S_EXEC_I:   state_nxt = S_I_WB;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_FETCH;
      endcase
      // the cycle after reset release only arms the FSM
      if (!run)
         state_nxt = state;
   end

   assign wait_clear = !run || (state_nxt != state);
   assign wait_en    = run && ((state == S_FETCH) || (state == S_MEM_READ));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run         <= 1'b0;
         state       <= S_FETCH;
         mem_is_lw   <= 1'b0;
         ctrl_q      <= '0;
         halted      <= 1'b0;
         illegal_op  <= 1'b0;
         instr_count <= '0;
      end else begin
         run    <= 1'b1;
         state  <= state_nxt;
         ctrl_q <= mc_decode(state_nxt, wait_done_nxt);
         halted <= (state_nxt == S_HALT);
         if (state == S_DECODE) begin
            mem_is_lw <= (opCode == OP_LW);
            if (op_bad)
               illegal_op <= 1'b1;
         end
         if ((state == S_FETCH) && wait_done)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   assign PCWriteCond = ctrl_q.pc_write_cond;
   assign PCWrite     = ctrl_q.pc_write;
   assign IorD        = ctrl_q.i_or_d;
   assign MemRead     = ctrl_q.mem_read;
   assign MemWrite    = ctrl_q.mem_write;
   assign MemtoReg    = ctrl_q.mem_to_reg;
   assign IRWrite     = ctrl_q.ir_write;
   assign ALUSrcA     = ctrl_q.alu_src_a;
   assign RegWrite    = ctrl_q.reg_write;
   assign RegDst      = ctrl_q.reg_dst;
   assign PCSource    = ctrl_q.pc_source;
   assign ALUOp       = ctrl_q.alu_op;
   assign ALUSrcB     = ctrl_q.alu_src_b;
   assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle tables built from the
// instruction phase rules, random opcode noise outside DECODE, reset cases.
module tb_multicycle_control;
   import mc_ctrl_pkg::*;

   localparam int ML    = 3;
   localparam int CNT_W = 32;

   // strobe word layout: {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,
   //  IRWrite,ALUSrcA,RegWrite,RegDst,PCSource[1:0],ALUOp[1:0],ALUSrcB[2:0]}
   localparam logic [16:0] B_PCWC = 17'h10000;
   localparam logic [16:0] B_PCW  = 17'h08000;
   localparam logic [16:0] B_IORD = 17'h04000;
   localparam logic [16:0] B_MR   = 17'h02000;
   localparam logic [16:0] B_MW   = 17'h01000;
   localparam logic [16:0] B_M2R  = 17'h00800;
   localparam logic [16:0] B_IRW  = 17'h00400;
   localparam logic [16:0] B_ASA  = 17'h00200;
   localparam logic [16:0] B_RW   = 17'h00100;
   localparam logic [16:0] B_RD   = 17'h00080;
   localparam logic [16:0] P_BR   = 17'h00020;
   localparam logic [16:0] P_J    = 17'h00040;
   localparam logic [16:0] A_SUB  = 17'h00008;
   localparam logic [16:0] A_FN   = 17'h00010;
   localparam logic [16:0] SB_4   = 17'h00001;
   localparam logic [16:0] SB_IMM = 17'h00002;
   localparam logic [16:0] SB_SH  = 17'h00003;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] sb;
      logic        fl;
      logic        ill;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [5:0]       opCode;
   logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
   logic             IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0]       PCSource, ALUOp;
   logic [2:0]       ALUSrcB;
   logic             halted, illegal_op;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       state_dbg;
   logic [16:0]      obs_sb;

   int   n_chk;
   int   n_err;
   int   m_cnt;
   exp_t q[$];
   logic [5:0] legal_ops[6];

   multicycle_control #(.MEM_LAT(ML), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .opCode      (opCode),
      .PCWriteCond (PCWriteCond),
      .PCWrite     (PCWrite),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .ALUSrcB     (ALUSrcB),
      .halted      (halted),
      .illegal_op  (illegal_op),
      .instr_count (instr_count),
      .state_dbg   (state_dbg)
   );

   assign obs_sb = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic void push(input state_t st, input logic [16:0] sb,
                                input logic fl, input logic ill);
      exp_t e;
      e.st  = st;
      e.sb  = sb;
      e.fl  = fl;
      e.ill = ill;
      q.push_back(e);
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_J) || (op == OP_ADDI) || (op == OP_HALT);
   endfunction

   // cycle-by-cycle expectation of one instruction from fetch to its last state
   function automatic void build(input logic [5:0] op, input int n_halt);
      q.delete();
      for (int i = 0; i <= ML; i++) begin
         if (i == ML) push(S_FETCH, B_MR | B_IRW | B_PCW | SB_4, 1'b1, 1'b0);
         else         push(S_FETCH, B_MR, 1'b0, 1'b0);
      end
      push(S_DECODE, SB_SH, 1'b0, 1'b0);
      if (op == OP_LW || op == OP_SW) begin
         push(S_MEM_ADDR, B_ASA | SB_IMM, 1'b0, 1'b0);
         if (op == OP_LW) begin
            for (int i = 0; i <= ML; i++) push(S_MEM_READ, B_MR | B_IORD, 1'b0, 1'b0);
            push(S_MEM_WB, B_RW | B_M2R, 1'b0, 1'b0);
         end else begin
            push(S_MEM_WRITE, B_MW | B_IORD, 1'b0, 1'b0);
         end
      end else if (op == OP_RTYPE) begin
         push(S_EXEC_R, B_ASA | A_FN, 1'b0, 1'b0);
         push(S_R_WB, B_ASA | A_FN | B_RW | B_RD, 1'b0, 1'b0);
      end else if (op == OP_ADDI) begin
         push(S_EXEC_I, B_ASA | SB_IMM, 1'b0, 1'b0);
         push(S_I_WB, B_ASA | SB_IMM | B_RW, 1'b0, 1'b0);
      end else if (op == OP_BEQ) begin
         push(S_BRANCH, B_ASA | A_SUB | B_PCWC | P_BR, 1'b0, 1'b0);
      end else if (op == OP_J) begin
         push(S_JUMP, B_PCW | P_J, 1'b0, 1'b0);
      end else begin
         for (int i = 0; i < n_halt; i++) push(S_HALT, 17'h0, 1'b0, op != OP_HALT);
      end
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_state"}, 64'(state_dbg), 64'(S_FETCH));
      chk({tag, "_strobes"}, 64'(obs_sb), 64'(0));
      chk({tag, "_halted"}, 64'(halted), 64'(0));
      chk({tag, "_illegal"}, 64'(illegal_op), 64'(0));
      chk({tag, "_count"}, 64'(instr_count), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_state("rst");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      m_cnt = 0;
      reset = 1'b1;
   endtask

   task automatic run_instr(input logic [5:0] op, input int n_halt, input bit abort_rd);
      build(op, n_halt);
      foreach (q[i]) begin
         @(posedge clk);
         @(negedge clk);
         chk("state", 64'(state_dbg), 64'(q[i].st));
         chk("strobes", 64'(obs_sb), 64'(q[i].sb));
         chk("halted", 64'(halted), 64'(q[i].st == S_HALT));
         chk("illegal", 64'(illegal_op), 64'(q[i].ill));
         chk("count", 64'(instr_count), 64'(m_cnt));
         if (q[i].fl) m_cnt++;
         if (q[i].st == S_DECODE) opCode = op;
         else                     opCode = 6'($urandom_range(0, 63));
         if (abort_rd && q[i].st == S_MEM_READ) begin
            #2 reset = 1'b0;
            #1;
            check_reset_state("async_rst");
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            m_cnt = 0;
            reset = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      logic [5:0] bad_op;
      n_chk = 0;
      n_err = 0;
      m_cnt = 0;
      reset = 1'b0;
      opCode = 6'h0;
      legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

      do_reset();
      run_instr(OP_RTYPE, 0, 1'b0);
      run_instr(OP_LW, 0, 1'b0);
      run_instr(OP_SW, 0, 1'b0);
      run_instr(OP_BEQ, 0, 1'b0);
      run_instr(OP_J, 0, 1'b0);
      run_instr(OP_ADDI, 0, 1'b0);
      repeat (30) run_instr(legal_ops[$urandom_range(0, 5)], 0, 1'b0);

      run_instr(OP_LW, 0, 1'b1);
      run_instr(OP_RTYPE, 0, 1'b0);
      run_instr(OP_SW, 0, 1'b0);

      run_instr(6'b010101, 20, 1'b0);
      do_reset();
      run_instr(OP_ADDI, 0, 1'b0);
      run_instr(OP_HALT, 20, 1'b0);
      do_reset();

      bad_op = 6'($urandom_range(0, 63));
      while (is_legal(bad_op)) bad_op = 6'($urandom_range(0, 63));
      run_instr(OP_J, 0, 1'b0);
      run_instr(bad_op, 5, 1'b0);
      do_reset();

      run_instr(OP_BEQ, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("final_state", 64'(state_dbg), 64'(S_FETCH));
      chk("final_count", 64'(instr_count), 64'(m_cnt));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
